// File: rtl/stopwatch_bcd_timer.sv
// rtl/stopwatch_bcd_timer.sv - N-digit BCD stopwatch/countdown timer with 7-segment outputs
// Optional lap/split display freeze is built when STOPWATCH_LAP_EN is defined.
module stopwatch_bcd_timer #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100,
  parameter int DIGITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   preset,
  input  logic                  dir,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  running,
  output logic                  done,
  output logic                  wrap,
  output logic                  lap_active
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t                state;
  logic [PW-1:0]         presc;
  logic [4*DIGITS-1:0]   count;
  logic [4*DIGITS-1:0]   count_inc;
  logic [4*DIGITS-1:0]   count_dec;
  logic [4*DIGITS-1:0]   preset_sat;
  logic                  inc_carry;
  logic                  dec_borrow;
  logic                  dec_zero;
  logic                  count_zero;
  logic                  dir_q;
  logic                  start_prev;
  logic                  stop_prev;
  logic                  start_edge;
  logic                  stop_edge;
  logic                  tick;
  logic                  load_ok;

  assign start_edge = start & ~start_prev;
  assign stop_edge  = stop & ~stop_prev;
  assign tick       = (presc == PRESC_MAX);
  assign count_zero = (count == '0);
  assign dec_zero   = (count_dec == '0);
  assign load_ok    = load && (state != S_RUN);

  // Ripple-carry BCD increment/decrement and per-digit preset saturation.
  always_comb begin
    count_inc  = '0;
    count_dec  = '0;
    preset_sat = '0;
    inc_carry  = 1'b1;
    dec_borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (inc_carry) begin
        if (count[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
          inc_carry = 1'b0;
        end
      end else begin
        count_inc[4*i +: 4] = count[4*i +: 4];
      end
      if (dec_borrow) begin
        if (count[4*i +: 4] == 4'd0) begin
          count_dec[4*i +: 4] = 4'd9;
        end else begin
          count_dec[4*i +: 4] = count[4*i +: 4] - 4'd1;
          dec_borrow = 1'b0;
        end
      end else begin
        count_dec[4*i +: 4] = count[4*i +: 4];
      end
      preset_sat[4*i +: 4] = (preset[4*i +: 4] > 4'd9) ? 4'd9 : preset[4*i +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      presc      <= '0;
      count      <= '0;
      dir_q      <= 1'b0;
      running    <= 1'b0;
      done       <= 1'b0;
      wrap       <= 1'b0;
      start_prev <= 1'b0;
      stop_prev  <= 1'b0;
    end else begin
      start_prev <= start;
      stop_prev  <= stop;
      wrap       <= 1'b0;
      if (clear) begin
        state   <= S_IDLE;
        presc   <= '0;
        count   <= '0;
        running <= 1'b0;
        done    <= 1'b0;
      end else if (load_ok) begin
        state   <= S_IDLE;
        presc   <= '0;
        count   <= preset_sat;
        running <= 1'b0;
        done    <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_PAUSE: begin
            // A down count cannot start from zero; a simultaneous stop edge also blocks start.
            if (!stop_edge && start_edge && !(dir && count_zero)) begin
              state   <= S_RUN;
              running <= 1'b1;
              dir_q   <= dir;
            end
          end
          S_RUN: begin
            if (stop_edge) begin
              state   <= S_PAUSE;
              running <= 1'b0;
            end else if (tick) begin
              presc <= '0;
              if (dir_q) begin
                count <= count_dec;
                if (dec_zero) begin
                  state   <= S_DONE;
                  running <= 1'b0;
                  done    <= 1'b1;
                end
              end else begin
                count <= count_inc;
                wrap  <= inc_carry;
              end
            end else begin
              presc <= presc + PW'(1);
            end
          end
          S_DONE: begin
            if (!stop_edge && start_edge && !dir) begin
              state   <= S_RUN;
              running <= 1'b1;
              dir_q   <= 1'b0;
              done    <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic                lap_prev;
  logic                lap_edge;
  logic [4*DIGITS-1:0] snap;

  assign lap_edge = lap & ~lap_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      lap_prev   <= 1'b0;
      lap_active <= 1'b0;
      snap       <= '0;
    end else begin
      lap_prev <= lap;
      if (clear || load_ok) begin
        lap_active <= 1'b0;
      end else if (lap_edge && (state == S_RUN || state == S_PAUSE)) begin
        lap_active <= ~lap_active;
        if (!lap_active) begin
          snap <= count;
        end
      end
    end
  end

  assign bcd = lap_active ? snap : count;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_active = 1'b0;
  assign bcd        = count;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    seg = '1;
    for (int i = 0; i < DIGITS; i++) begin
      seg[7*i +: 7] = seg7(bcd[4*i +: 4]);
    end
  end

endmodule

// File: tb/tb_stopwatch_bcd_timer.sv
// tb/tb_stopwatch_bcd_timer.sv - directed self-checking bench for stopwatch_bcd_timer
// Runs 2 digits at DIV=10; lap expectations follow STOPWATCH_LAP_EN.
module tb_stopwatch_bcd_timer;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S9 = 7'b0010000;

  logic        clk = 1'b0;
  logic        rst, start, stop, clear, load, dir, lap;
  logic [7:0]  preset;
  logic [7:0]  bcd;
  logic [13:0] seg;
  logic        running, done, wrap, lap_active;

  int n_pass  = 0;
  int n_total = 0;

  stopwatch_bcd_timer #(
    .CLK_HZ (1000),
    .TICK_HZ(100),
    .DIGITS (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .load      (load),
    .preset    (preset),
    .dir       (dir),
    .lap       (lap),
    .bcd       (bcd),
    .seg       (seg),
    .running   (running),
    .done      (done),
    .wrap      (wrap),
    .lap_active(lap_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; @(negedge clk); stop = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1; @(negedge clk); lap = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; @(negedge clk); clear = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] v);
    preset = v; load = 1'b1; @(negedge clk); load = 1'b0;
  endtask

  logic [7:0] exp_lap_bcd;
  logic       exp_lap_act;

  initial begin
    rst = 1'b1; start = 0; stop = 0; clear = 0; load = 0; dir = 0; lap = 0; preset = 8'h00;
    wait_n(3);
    rst = 1'b0;
    check("rst_bcd", bcd, 8'h00);
    check("rst_seg", seg, {S0, S0});
    check("rst_flags", {running, done, wrap, lap_active}, 4'b0000);

    // Up count from zero
    dir = 1'b0;
    pulse_start();
    check("up_running", running, 1'b1);
    wait_n(9);
    check("up_pre_tick", bcd, 8'h00);
    wait_n(1);
    check("up_first_tick", bcd, 8'h01);
    wait_n(90);
    check("up_100clk", bcd, 8'h10);
    check("up_seg_10", seg, {S1, S0});
    do_clear();

    // Rollover from 99
    do_load(8'h99);
    check("load_99", bcd, 8'h99);
    pulse_start();
    wait_n(9);
    check("wrap_pre", {bcd, wrap}, {8'h99, 1'b0});
    wait_n(1);
    check("wrap_bcd", bcd, 8'h00);
    check("wrap_pulse", {wrap, running}, 2'b11);
    wait_n(1);
    check("wrap_one_cycle", {wrap, running}, 2'b01);
    do_clear();

    // Countdown to done
    do_load(8'h03);
    dir = 1'b1;
    pulse_start();
    wait_n(10);
    check("down_02", bcd, 8'h02);
    wait_n(10);
    check("down_01", bcd, 8'h01);
    check("down_not_done", done, 1'b0);
    wait_n(10);
    check("down_00", bcd, 8'h00);
    check("down_done", {done, running}, 2'b10);
    wait_n(20);
    check("done_hold", {bcd, done, running}, {8'h00, 1'b1, 1'b0});
    pulse_start();
    wait_n(15);
    check("done_start_dir1", {bcd, done, running}, {8'h00, 1'b1, 1'b0});
    dir = 1'b0;
    pulse_start();
    check("done_start_dir0", {done, running}, 2'b01);
    do_clear();
    check("clear_after_done", {bcd, done, running}, {8'h00, 1'b0, 1'b0});

    // Simultaneous start/stop in IDLE, then pause at prescaler 4
    start = 1'b1; stop = 1'b1; @(negedge clk); start = 1'b0; stop = 1'b0;
    check("start_stop_idle", running, 1'b0);
    wait_n(12);
    check("start_stop_bcd", bcd, 8'h00);
    pulse_start();
    wait_n(4);
    pulse_stop();
    check("pause_running", running, 1'b0);
    wait_n(20);
    check("pause_hold", bcd, 8'h00);
    pulse_start();
    check("resume_running", running, 1'b1);
    wait_n(5);
    check("resume_pre_tick", bcd, 8'h00);
    wait_n(1);
    check("resume_tick_6", bcd, 8'h01);

    // load ignored in RUN, clear in RUN, saturating load
    do_load(8'h55);
    check("load_in_run", {bcd, running}, {8'h01, 1'b1});
    do_clear();
    check("clear_in_run", {bcd, running}, {8'h00, 1'b0});
    do_load(8'hFA);
    check("load_sat", bcd, 8'h99);
    check("load_sat_seg", seg, {S9, S9});
    do_clear();

    // Lap freeze / release
`ifdef STOPWATCH_LAP_EN
    exp_lap_bcd = 8'h05; exp_lap_act = 1'b1;
`else
    exp_lap_bcd = 8'h05; exp_lap_act = 1'b0;
`endif
    pulse_start();
    wait_n(50);
    check("lap_pre", bcd, 8'h05);
    pulse_lap();
    check("lap_freeze_bcd", bcd, exp_lap_bcd);
    check("lap_freeze_act", lap_active, exp_lap_act);
    wait_n(69);
`ifdef STOPWATCH_LAP_EN
    exp_lap_bcd = 8'h05;
`else
    exp_lap_bcd = 8'h12;
`endif
    check("lap_held", bcd, exp_lap_bcd);
    pulse_lap();
    check("lap_release_bcd", bcd, 8'h12);
    check("lap_release_act", lap_active, 1'b0);

    // Reset mid-count
    wait_n(25);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    check("midrst_bcd", bcd, 8'h00);
    check("midrst_seg", seg, {S0, S0});
    check("midrst_flags", {running, done, wrap, lap_active}, 4'b0000);
    wait_n(15);
    check("midrst_idle", {bcd, running}, {8'h00, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
